// File: rtl/fft_stage_sequencer.sv
// Level sequencer for the in-place radix-2 FFT: launches one address-generator
// pass per level, drains the butterfly pipeline, and hands the RAM back.
module fft_stage_sequencer #(
    parameter int LEVELS       = 12,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    output logic                      ready,
    output logic                      done,
    output logic                      aborted,
    output logic                      mem_sel,
    output logic                      addr_gen_go,
    input  logic                      addr_gen_busy,
    input  logic                      fft_data_valid,
    output logic [$clog2(LEVELS)-1:0] fft_level,
    output logic                      level_done
);
    localparam int LW = $clog2(LEVELS);
    localparam int CW = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [LW-1:0] LAST_LEVEL = LW'(LEVELS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [1:0]    WAIT_LAST  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        r_state, w_state_next;
    logic [LW-1:0] r_level, w_level_next;
    logic [CW-1:0] r_drain_cnt, w_drain_cnt_next;
    logic [1:0]    r_wait_cnt, w_wait_cnt_next;
    logic [CW-1:0] w_drain_sat;
    logic          w_drain_exit;
    logic          w_abort_exit;
    logic          w_abortable;

    logic r_ready, r_done, r_aborted, r_mem_sel, r_go, r_level_done;

    // Drain counter saturates at its limit while the pipeline is still writing back.
    assign w_drain_sat = (r_drain_cnt == DRAIN_LAST) ? r_drain_cnt : r_drain_cnt + CW'(1);
    assign w_abortable = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY) ||
                         (r_state == S_RUN)   || (r_state == S_DRAIN);

    always_comb begin
        w_state_next     = r_state;
        w_level_next     = r_level;
        w_drain_cnt_next = r_drain_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_drain_exit     = 1'b0;
        w_abort_exit     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_ISSUE;
                    w_level_next = '0;
                end
            end
            S_ISSUE: begin
                w_state_next    = S_WAIT_BUSY;
                w_wait_cnt_next = '0;
            end
            S_WAIT_BUSY: begin
                // Bounded wait so a generator that never raises busy cannot hang us.
                if (addr_gen_busy || (r_wait_cnt == WAIT_LAST)) begin
                    w_state_next = S_RUN;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 2'd1;
                end
            end
            S_RUN: begin
                if (!addr_gen_busy) begin
                    w_state_next     = S_DRAIN;
                    w_drain_cnt_next = '0;
                end
            end
            S_DRAIN: begin
                w_drain_cnt_next = w_drain_sat;
                if ((r_drain_cnt == DRAIN_LAST) && !fft_data_valid) begin
                    w_drain_exit = 1'b1;
                    if (r_level == LAST_LEVEL) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_level_next = r_level + LW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_level_next = '0;
            end
            S_ABORT: begin
                // The in-flight pass must finish and drain before the RAM is released.
                if (addr_gen_busy) begin
                    w_drain_cnt_next = '0;
                end else if ((r_drain_cnt == DRAIN_LAST) && !fft_data_valid) begin
                    w_abort_exit = 1'b1;
                    w_state_next = S_IDLE;
                    w_level_next = '0;
                end else begin
                    w_drain_cnt_next = w_drain_sat;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_level_next = '0;
            end
        endcase

        if (abort && w_abortable) begin
            w_state_next     = S_ABORT;
            w_level_next     = r_level;
            w_drain_cnt_next = '0;
            w_drain_exit     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_level      <= '0;
            r_drain_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_mem_sel    <= 1'b0;
            r_go         <= 1'b0;
            r_level_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_level      <= w_level_next;
            r_drain_cnt  <= w_drain_cnt_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_ready      <= (w_state_next == S_IDLE);
            r_done       <= (w_state_next == S_DONE);
            r_aborted    <= w_abort_exit;
            r_mem_sel    <= (w_state_next != S_IDLE);
            r_go         <= (w_state_next == S_ISSUE);
            r_level_done <= w_drain_exit;
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign mem_sel     = r_mem_sel;
    assign addr_gen_go = r_go;
    assign fft_level   = r_level;
    assign level_done  = r_level_done;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer driving a behavioural address generator
// (busy for a programmable length) and a 7-cycle butterfly valid pipeline.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
    localparam int LEVELS       = 12;
    localparam int DRAIN_CYCLES = 8;
    localparam int PIPE_LAT     = 7;
    localparam int LW           = $clog2(LEVELS);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready, done, aborted, mem_sel, addr_gen_go, level_done;
    logic addr_gen_busy, fft_data_valid;
    logic [LW-1:0] fft_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .LEVELS       (LEVELS),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .ready          (ready),
        .done           (done),
        .aborted        (aborted),
        .mem_sel        (mem_sel),
        .addr_gen_go    (addr_gen_go),
        .addr_gen_busy  (addr_gen_busy),
        .fft_data_valid (fft_data_valid),
        .fft_level      (fft_level),
        .level_done     (level_done)
    );

    // Behavioural generator: busy for busy_len cycles starting the cycle after go;
    // valid is busy delayed PIPE_LAT, optionally held stretch_len cycles after busy falls.
    int busy_len    = 2048;
    int stretch_len = 0;
    int busy_cnt;
    int hold_cnt;
    logic busy_d;
    logic [PIPE_LAT-1:0] vpipe;

    always @(posedge clk) begin
        if (reset) begin
            addr_gen_busy <= 1'b0;
            busy_cnt      <= 0;
            busy_d        <= 1'b0;
            vpipe         <= '0;
            hold_cnt      <= 0;
        end else begin
            busy_d <= addr_gen_busy;
            vpipe  <= {vpipe[PIPE_LAT-2:0], addr_gen_busy};
            if (addr_gen_go) begin
                addr_gen_busy <= 1'b1;
                busy_cnt      <= busy_len - 1;
            end else if (addr_gen_busy) begin
                if (busy_cnt == 0) addr_gen_busy <= 1'b0;
                else               busy_cnt      <= busy_cnt - 1;
            end
            if (busy_d && !addr_gen_busy) hold_cnt <= stretch_len;
            else if (hold_cnt != 0)       hold_cnt <= hold_cnt - 1;
        end
    end
    assign fft_data_valid = vpipe[PIPE_LAT-1] || (hold_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor statistics, sampled 2 ns after each rising edge.
    int n_go, n_ldone, n_done, n_abt;
    int order_err, lvl_err, cross_err, memsel_cyc;
    int first_go_cyc, last_go_cyc, min_gap, max_gap;
    int done_cyc, abt_cyc, last_ldone_cyc, memsel_fall_cyc;
    logic [LW-1:0] prev_level = '0;
    logic prev_busy = 1'b0, prev_valid = 1'b0, prev_memsel = 1'b0;

    task automatic clear_stats();
        n_go = 0; n_ldone = 0; n_done = 0; n_abt = 0;
        order_err = 0; lvl_err = 0; cross_err = 0; memsel_cyc = 0;
        first_go_cyc = -1; last_go_cyc = -1; min_gap = 1 << 30; max_gap = 0;
        done_cyc = -1; abt_cyc = -1; last_ldone_cyc = -1; memsel_fall_cyc = -1;
    endtask

    always begin : monitor
        int gap;
        @(posedge clk);
        #2;
        if (addr_gen_go) begin
            if (n_go == 0) begin
                first_go_cyc = cyc;
            end else begin
                gap = cyc - last_go_cyc;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            if (int'(fft_level) != n_go) order_err++;
            last_go_cyc = cyc;
            n_go++;
        end
        if (level_done) begin n_ldone++; last_ldone_cyc = cyc; end
        if (done)       begin n_done++;  done_cyc = cyc;       end
        if (aborted)    begin n_abt++;   abt_cyc = cyc;        end
        if (!reset && (fft_level != prev_level) &&
            (addr_gen_busy || fft_data_valid || prev_busy || prev_valid)) lvl_err++;
        if (mem_sel == ready) cross_err++;
        if (mem_sel) memsel_cyc++;
        if (prev_memsel && !mem_sel && memsel_fall_cyc < 0) memsel_fall_cyc = cyc;
        prev_level  = fft_level;
        prev_busy   = addr_gen_busy;
        prev_valid  = fft_data_valid;
        prev_memsel = mem_sel;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cur_count(input int which);
        case (which)
            0:       return n_go;
            1:       return n_done;
            default: return n_abt;
        endcase
    endfunction

    // Waits (bounded) until the selected monitor counter reaches target; 0=go 1=done 2=aborted.
    task automatic wait_count(input int which, input int target, input int limit, input string tag);
        int k;
        k = 0;
        while (cur_count(which) < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (cur_count(which) < target) check_eq({tag, "_timeout"}, cur_count(which), target);
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    int s_cyc, g_cyc, d_cyc, go_snap;

    initial begin
        clear_stats();
        reset = 1'b1;
        tick(3);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_mem_sel", mem_sel, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_aborted", aborted, 0);
        check_eq("rst_go", addr_gen_go, 0);
        check_eq("rst_level_done", level_done, 0);
        check_eq("rst_fft_level", fft_level, 0);
        reset = 1'b0;
        tick(2);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(4);
        check_eq("idle_abort_ready", ready, 1);
        check_eq("idle_abort_pulse", n_abt, 0);
        $display("idle abort: ready=%0d aborted_pulses=%0d", ready, n_abt);

        // Full 12-level transform with a 2048-cycle generator pass.
        busy_len = 2048; stretch_len = 0;
        clear_stats();
        pulse_start(s_cyc);
        wait_count(1, 1, 30000, "full_done");
        tick(3);
        check_eq("full_go_count", n_go, 12);
        check_eq("full_go_order", order_err, 0);
        check_eq("full_level_done", n_ldone, 12);
        check_eq("full_done_count", n_done, 1);
        check_eq("full_abort_count", n_abt, 0);
        check_eq("full_first_go", first_go_cyc - s_cyc, 1);
        check_eq("full_min_gap", min_gap, 2058);
        check_eq("full_max_gap", max_gap, 2058);
        check_eq("full_done_at", done_cyc - first_go_cyc, 12 * 2058);
        check_eq("full_last_ldone", last_ldone_cyc, done_cyc);
        check_eq("full_memsel_cycles", memsel_cyc, 12 * 2058 + 1);
        check_eq("full_memsel_fall", memsel_fall_cyc - done_cyc, 1);
        check_eq("full_level_stable", lvl_err, 0);
        check_eq("full_ready_vs_memsel", cross_err, 0);
        check_eq("full_end_level", fft_level, 0);
        check_eq("full_end_ready", ready, 1);
        $display("full transform: gos=%0d level_dones=%0d gap=%0d done_after=%0d",
                 n_go, n_ldone, min_gap, done_cyc - first_go_cyc);

        // Abort during level 5 RUN.
        busy_len = 40;
        clear_stats();
        pulse_start(s_cyc);
        wait_count(0, 6, 2000, "abort_go5");
        g_cyc = last_go_cyc;
        tick(9);
        check_eq("abort_pre_level", fft_level, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_count(2, 1, 500, "abort_pulse");
        tick(100);
        check_eq("abort_go_count", n_go, 6);
        check_eq("abort_pulse_count", n_abt, 1);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_pulse_at", abt_cyc - g_cyc, 49);
        check_eq("abort_memsel_fall", memsel_fall_cyc, abt_cyc);
        check_eq("abort_level_dones", n_ldone, 5);
        check_eq("abort_end_level", fft_level, 0);
        check_eq("abort_end_memsel", mem_sel, 0);
        check_eq("abort_end_ready", ready, 1);
        check_eq("abort_level_stable", lvl_err, 0);
        $display("abort transform: gos=%0d aborted_at=+%0d done=%0d", n_go, abt_cyc - g_cyc, n_done);

        // Valid held 20 cycles after busy falls stretches every drain.
        busy_len = 40; stretch_len = 20;
        clear_stats();
        pulse_start(s_cyc);
        wait_count(1, 1, 3000, "stretch_done");
        tick(3);
        stretch_len = 0;
        check_eq("stretch_go_count", n_go, 12);
        check_eq("stretch_min_gap", min_gap, 63);
        check_eq("stretch_max_gap", max_gap, 63);
        check_eq("stretch_done_at", done_cyc - first_go_cyc, 12 * 63);
        check_eq("stretch_go_order", order_err, 0);
        check_eq("stretch_level_stable", lvl_err, 0);
        $display("stretched transform: gos=%0d gap=%0d done=%0d", n_go, min_gap, n_done);

        // start held high: one transform, then a new one right after IDLE.
        busy_len = 40;
        clear_stats();
        start = 1'b1;
        wait_count(1, 1, 3000, "held_done");
        check_eq("held_go_count", n_go, 12);
        check_eq("held_done_count", n_done, 1);
        d_cyc = done_cyc;
        clear_stats();
        wait_count(0, 1, 20, "held_restart");
        check_eq("held_restart_at", first_go_cyc - d_cyc, 2);
        check_eq("held_restart_ready", ready, 0);
        start = 1'b0;
        $display("start held: restart_after_done=%0d", first_go_cyc - d_cyc);

        // Reset in the middle of level 3 of the second transform.
        wait_count(0, 4, 1000, "reset_lvl3");
        tick(10);
        check_eq("reset_pre_level", fft_level, 3);
        reset = 1'b1;
        tick();
        check_eq("reset_ready", ready, 1);
        check_eq("reset_memsel", mem_sel, 0);
        check_eq("reset_level", fft_level, 0);
        check_eq("reset_go", addr_gen_go, 0);
        reset = 1'b0;
        go_snap = n_go;
        tick(100);
        check_eq("reset_no_go", n_go, go_snap);
        check_eq("reset_idle_ready", ready, 1);
        $display("mid-level reset: gos_after_reset=%0d", n_go - go_snap);

        // Clean transform after the reset.
        clear_stats();
        pulse_start(s_cyc);
        wait_count(1, 1, 3000, "post_reset_done");
        tick(3);
        check_eq("post_go_count", n_go, 12);
        check_eq("post_go_order", order_err, 0);
        check_eq("post_done_count", n_done, 1);
        check_eq("post_min_gap", min_gap, 50);
        check_eq("post_max_gap", max_gap, 50);
        check_eq("post_abort_count", n_abt, 0);
        $display("post-reset transform: gos=%0d gap=%0d done=%0d", n_go, min_gap, n_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
